// File: rtl/axi_timer_mc.sv
// N_CH prescaled up-counters with sticky masked IRQs; define TIMER_SHADOW_PERIOD_EN for a shadowed PERIOD.
// Read data is valid the cycle after address accept and is held until i_rready; one transaction in flight at a time.
module axi_timer_mc #(
    parameter int N_CH   = 4,
    parameter int CNT_W  = 32,
    parameter int ADDR_W = 8,
    parameter int PSC_W  = 16
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_avalid,
    input  logic              i_awrite,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              o_aready,
    input  logic              i_wvalid,
    input  logic [31:0]       i_wdata,
    output logic              o_wready,
    output logic              o_rvalid,
    output logic [31:0]       o_rdata,
    input  logic              i_rready,
    output logic              o_irq
);
    typedef enum logic [1:0] {ST_IDLE, ST_WDATA, ST_RDATA} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              gcr_en_q, gcr_en_d;
    logic [N_CH-1:0]   status_q, status_d;
    logic [N_CH-1:0]   mask_q, mask_d;
    logic [N_CH-1:0]   ch_en_q, ch_en_d;
    logic [N_CH-1:0]   ch_mode_q, ch_mode_d;
    logic [PSC_W-1:0]  prescale_q, prescale_d;
    logic [PSC_W-1:0]  psc_cnt_q, psc_cnt_d;
    logic [CNT_W-1:0]  period_q  [N_CH];
    logic [CNT_W-1:0]  period_d  [N_CH];
`ifdef TIMER_SHADOW_PERIOD_EN
    logic [CNT_W-1:0]  period_sh_q [N_CH];
    logic [CNT_W-1:0]  period_sh_d [N_CH];
`endif
    logic [CNT_W-1:0]  counter_q [N_CH];
    logic [CNT_W-1:0]  counter_d [N_CH];
    logic [CNT_W-1:0]  irq_cnt_q [N_CH];
    logic [CNT_W-1:0]  irq_cnt_d [N_CH];
    logic              irq_q, irq_d;

    logic              wr_en, tick;
    logic              wr_gcr, wr_status, wr_mask, wr_prescale;
    logic [ADDR_W-1:0] rd_off, wr_off;
    logic              rd_in_ch, wr_in_ch;
    logic [N_CH-1:0]   rd_hit, wr_hit, expire, w1c;
    logic [31:0]       rd_mux;

    // Channel windows start at word 0x10, four registers per channel.
    assign rd_off      = i_addr - ADDR_W'(16);
    assign wr_off      = addr_q - ADDR_W'(16);
    assign rd_in_ch    = (i_addr >= ADDR_W'(16));
    assign wr_in_ch    = (addr_q >= ADDR_W'(16));
    assign wr_gcr      = wr_en && (addr_q == ADDR_W'(0));
    assign wr_status   = wr_en && (addr_q == ADDR_W'(1));
    assign wr_mask     = wr_en && (addr_q == ADDR_W'(2));
    assign wr_prescale = wr_en && (addr_q == ADDR_W'(3));

    always_comb begin
        rd_hit = '0;
        wr_hit = '0;
        for (int c = 0; c < N_CH; c++) begin
            rd_hit[c] = rd_in_ch && (rd_off[ADDR_W-1:2] == (ADDR_W-2)'(c));
            wr_hit[c] = wr_en && wr_in_ch && (wr_off[ADDR_W-1:2] == (ADDR_W-2)'(c));
        end
    end

    always_comb begin
        rd_mux = '0;
        if (i_addr == ADDR_W'(0))      rd_mux = 32'(gcr_en_q);
        else if (i_addr == ADDR_W'(1)) rd_mux = 32'(status_q);
        else if (i_addr == ADDR_W'(2)) rd_mux = 32'(mask_q);
        else if (i_addr == ADDR_W'(3)) rd_mux = 32'(prescale_q);
        for (int c = 0; c < N_CH; c++) begin
            if (rd_hit[c]) begin
                case (rd_off[1:0])
                    2'd0: rd_mux = 32'({ch_mode_q[c], ch_en_q[c]});
`ifdef TIMER_SHADOW_PERIOD_EN
                    2'd1: rd_mux = 32'(period_sh_q[c]);
`else
                    2'd1: rd_mux = 32'(period_q[c]);
`endif
                    2'd2: rd_mux = 32'(counter_q[c]);
                    default: rd_mux = 32'(irq_cnt_q[c]);
                endcase
            end
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rdata_d = rdata_q;
        wr_en   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_avalid) begin
                    addr_d = i_addr;
                    if (i_awrite) begin
                        state_d = ST_WDATA;
                    end else begin
                        state_d = ST_RDATA;
                        rdata_d = rd_mux;
                    end
                end
            end
            ST_WDATA: begin
                if (i_wvalid) begin
                    wr_en   = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_RDATA: begin
                if (i_rready) begin
                    rdata_d = '0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        gcr_en_d   = gcr_en_q;
        mask_d     = mask_q;
        prescale_d = prescale_q;
        ch_en_d    = ch_en_q;
        ch_mode_d  = ch_mode_q;
        period_d   = period_q;
        counter_d  = counter_q;
        irq_cnt_d  = irq_cnt_q;
`ifdef TIMER_SHADOW_PERIOD_EN
        period_sh_d = period_sh_q;
`endif
        expire = '0;

        tick      = gcr_en_q && (psc_cnt_q == prescale_q);
        psc_cnt_d = (!gcr_en_q || tick || wr_prescale) ? '0 : psc_cnt_q + PSC_W'(1);

        if (wr_gcr)      gcr_en_d   = i_wdata[0];
        if (wr_mask)     mask_d     = i_wdata[N_CH-1:0];
        if (wr_prescale) prescale_d = i_wdata[PSC_W-1:0];

        for (int c = 0; c < N_CH; c++) begin
            if (tick && ch_en_q[c]) begin
                if (counter_q[c] == period_q[c]) begin
                    expire[c]    = 1'b1;
                    counter_d[c] = '0;
                    if (irq_cnt_q[c] != {CNT_W{1'b1}}) irq_cnt_d[c] = irq_cnt_q[c] + CNT_W'(1);
                    if (ch_mode_q[c]) ch_en_d[c] = 1'b0;
`ifdef TIMER_SHADOW_PERIOD_EN
                    period_d[c] = period_sh_q[c];
`endif
                end else begin
                    counter_d[c] = counter_q[c] + CNT_W'(1);
                end
            end
            // Bus writes are applied last so they override the tick update.
            if (wr_hit[c]) begin
                case (wr_off[1:0])
                    2'd0: begin
                        ch_en_d[c]   = i_wdata[0];
                        ch_mode_d[c] = i_wdata[1];
                    end
                    2'd1: begin
`ifdef TIMER_SHADOW_PERIOD_EN
                        period_sh_d[c] = i_wdata[CNT_W-1:0];
                        if (!ch_en_q[c]) period_d[c] = i_wdata[CNT_W-1:0];
`else
                        period_d[c] = i_wdata[CNT_W-1:0];
`endif
                    end
                    2'd2:    counter_d[c] = i_wdata[CNT_W-1:0];
                    default: irq_cnt_d[c] = '0;
                endcase
            end
        end

        // Clear before set: an expiry in the same cycle as its W1C keeps the bit.
        w1c      = wr_status ? i_wdata[N_CH-1:0] : {N_CH{1'b0}};
        status_d = (status_q & ~w1c) | expire;
        irq_d    = |(status_q & mask_q);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            rdata_q    <= '0;
            gcr_en_q   <= 1'b0;
            status_q   <= '0;
            mask_q     <= '0;
            ch_en_q    <= '0;
            ch_mode_q  <= '0;
            prescale_q <= '0;
            psc_cnt_q  <= '0;
            irq_q      <= 1'b0;
            for (int c = 0; c < N_CH; c++) begin
                period_q[c]  <= '0;
                counter_q[c] <= '0;
                irq_cnt_q[c] <= '0;
`ifdef TIMER_SHADOW_PERIOD_EN
                period_sh_q[c] <= '0;
`endif
            end
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            rdata_q    <= rdata_d;
            gcr_en_q   <= gcr_en_d;
            status_q   <= status_d;
            mask_q     <= mask_d;
            ch_en_q    <= ch_en_d;
            ch_mode_q  <= ch_mode_d;
            prescale_q <= prescale_d;
            psc_cnt_q  <= psc_cnt_d;
            irq_q      <= irq_d;
            for (int c = 0; c < N_CH; c++) begin
                period_q[c]  <= period_d[c];
                counter_q[c] <= counter_d[c];
                irq_cnt_q[c] <= irq_cnt_d[c];
`ifdef TIMER_SHADOW_PERIOD_EN
                period_sh_q[c] <= period_sh_d[c];
`endif
            end
        end
    end

    assign o_aready = (state_q == ST_IDLE);
    assign o_wready = (state_q == ST_WDATA);
    assign o_rvalid = (state_q == ST_RDATA);
    assign o_rdata  = rdata_q;
    assign o_irq    = irq_q;

endmodule

// File: doc/axi_timer_mc.md
Name: axi_timer_mc

Overview:
Multi-channel successor to the single-channel AXI timer. Provides N_CH independent up-counters of CNT_W bits behind one shared prescaler, with a per-channel periodic/one-shot mode and per-channel expiry counters. Exposes a masked, sticky IRQ status vector and one combined interrupt output. Sits on the peripheral bus as a slave using the team's simple address/write/read-channel handshake.

Parameters:
N_CH, 4, number of timer channels (1..16)
CNT_W, 32, counter/period/irq-count width (8..32); register reads zero-extend to 32 bits
ADDR_W, 8, word-address width of ADDR
PSC_W, 16, prescaler width

Ports:
i_clk  in  1  clock
i_rst_n  in  1  asynchronous active-low reset
i_avalid  in  1  address phase valid
i_awrite  in  1  1 = write transaction, 0 = read
i_addr  in  ADDR_W  register word address
o_aready  out  1  address accepted
i_wvalid  in  1  write data valid
i_wdata  in  32  write data
o_wready  out  1  write data accepted
o_rvalid  out  1  read data valid
o_rdata  out  32  read data
i_rready  in  1  master accepts read data
o_irq  out  1  OR of (IRQ_STATUS & IRQ_MASK)

Behaviour:
- Reset (async, i_rst_n low): all registers 0, FSM IDLE. Outputs: o_aready=1, o_wready=0, o_rvalid=0, o_rdata=0, o_irq=0.
- Bus FSM, states IDLE/WDATA/RDATA:
  - IDLE: o_aready=1. On i_avalid, latch i_addr and go to WDATA if i_awrite, else RDATA.
  - WDATA: o_wready=1. On i_wvalid, write the register and return to IDLE.
  - RDATA: o_rvalid=1 starting the cycle after the address is accepted. o_rdata is captured on entry and held stable until i_rready; return to IDLE with o_rvalid=0 and o_rdata=0.
  - One transaction at a time. o_aready=0 outside IDLE.
- Register map (word addresses):
  - 0x00 GCR: bit0 global enable.
  - 0x01 IRQ_STATUS: bits[N_CH-1:0], write-1-to-clear.
  - 0x02 IRQ_MASK: bits[N_CH-1:0].
  - 0x03 PRESCALE: PSC_W bits.
  - Channel c, base 0x10+4*c:
    - +0 CTRL: bit0 enable, bit1 mode (0 periodic, 1 one-shot).
    - +1 PERIOD.
    - +2 COUNTER: a write loads the counter.
    - +3 IRQ_CNT: a write of any value clears it.
  - Unmapped or out-of-range channel addresses: reads return 0, writes are ignored, the handshake still completes.
- Prescaler:
  - Runs while GCR.en=1 and produces a 1-cycle tick every PRESCALE+1 cycles.
  - Clears to 0 when GCR.en=0 or when PRESCALE is written.
  - PRESCALE=0 gives a tick every cycle.
- Channel c on tick with CTRL.en=1:
  - If COUNTER==PERIOD (expiry): COUNTER←0, STATUS[c]←1, IRQ_CNT←IRQ_CNT+1 (saturates at all-ones). In one-shot mode CTRL.en←0 in the same cycle.
  - Otherwise COUNTER←COUNTER+1.
  - PERIOD=0 expires on every tick. COUNTER>PERIOD (after a software load) counts up, wraps through all-ones to 0, then reaches PERIOD.
- Collisions:
  - A bus write to COUNTER/CTRL/IRQ_CNT in the same cycle as a tick wins over the tick update of that field.
  - Expiry together with a W1C of the same STATUS bit leaves the bit set.
- o_irq is registered: it reflects STATUS/MASK one cycle after they change.
- A disabled channel holds its COUNTER value. Re-enabling resumes from that value.

Optional Feature:
TIMER_SHADOW_PERIOD_EN.
- Defined: each channel has a shadow PERIOD. Bus writes go to the shadow, and reads of PERIOD return the shadow. The active period loads from the shadow on expiry, or immediately if the channel is disabled.
- Undefined: PERIOD writes take effect on the next compare.

Test Plan:
1. Reset mid-read (o_rvalid=1) -> o_rvalid=0, o_aready=1, all registers read back 0 afterwards.
2. PRESCALE=0, ch0 PERIOD=3, periodic, GCR.en=1 -> STATUS[0] rises every 4 clocks; after 3 expiries IRQ_CNT=3; o_irq=1 only when MASK[0]=1.
3. ch1 one-shot, PERIOD=2, PRESCALE=1 -> single expiry after 6 clocks; CTRL1 reads 0x2 (en cleared); COUNTER stays 0.
4. W1C of STATUS bit 2 in the same cycle ch2 expires -> bit 2 remains 1; the next W1C clears it and o_irq drops one cycle later.
5. CNT_W=8, IRQ_CNT preloaded near limit (counting expiries past 255) -> saturates at 0xFF; a write clears it to 0. COUNTER loaded with 0xFE, PERIOD=1 -> sequence 0xFF,0x00,0x01, then expiry.
6. Read/write to address 0x7F and to channel N_CH -> read data 0, no register change, handshakes complete without hang; back-to-back transactions accepted.
